// File: rtl/edge_packer.sv
// edge_packer
//   Packs a serial stream of edge bits into bytes, MSB first, and buffers the
//   bytes in a small FIFO for a ready/valid consumer. A tile is TILE_BITS
//   bits long. The last byte of a tile may hold fewer than 8 bits. In that
//   case its unused LSBs are zero and the byte is tagged out_last.
//   The producer side never sees backpressure. If a byte completes while the
//   FIFO is full and nothing pops in that cycle, the byte is dropped and the
//   sticky overflow flag is set.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high
//   edge_in     edge bit, sampled only when edge_valid=1
//   edge_valid  qualifier for edge_in
//   out_data    byte at the FIFO head (0 while empty)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head byte when out_valid=1
//   out_last    head byte is the final byte of a tile
//   tile_done   one-cycle pulse after a last-tagged byte is popped
//   overflow    sticky: a completed byte was dropped
//   tile_count  number of tiles fully popped, wraps at 256
module edge_packer #(
  parameter int TILE_BITS  = 324,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edge_in,
  input  logic       edge_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       tile_done,
  output logic       overflow,
  output logic [7:0] tile_count
);

  localparam int PIX_W = (TILE_BITS > 1) ? $clog2(TILE_BITS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TILE_BITS - 1);

  // Packer state
  logic [2:0]       bit_cnt_reg;
  logic [PIX_W-1:0] pix_cnt_reg;
  logic [7:0]       shift_reg;  // bits already placed at their final positions

  // FIFO state. The pointers carry one extra wrap bit, which tells a full
  // FIFO apart from an empty one.
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [7:0]       mem_data [FIFO_DEPTH];
  logic             mem_last [FIFO_DEPTH];

  logic             overflow_reg;
  logic             tile_done_reg;
  logic [7:0]       tile_count_reg;

  logic             tile_end;
  logic             byte_done;
  logic [7:0]       byte_word;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  assign wr_idx = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx = rd_ptr_reg[PTR_W-1:0];

  always_comb begin
    tile_end   = (pix_cnt_reg == PIX_LAST);
    byte_done  = edge_valid && ((bit_cnt_reg == 3'd7) || tile_end);
    // Place the incoming bit at position 7-bit_cnt. Bits that were never
    // written stay zero, so a short final byte is padded automatically.
    byte_word  = shift_reg | (8'(edge_in) << (3'd7 - bit_cnt_reg));
    fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_idx == rd_idx);
    pop        = !fifo_empty && out_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot in time.
    push       = byte_done && (!fifo_full || pop);
    drop       = byte_done && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_reg    <= '0;
      pix_cnt_reg    <= '0;
      shift_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      overflow_reg   <= 1'b0;
      tile_done_reg  <= 1'b0;
      tile_count_reg <= '0;
    end else begin
      if (edge_valid) begin
        if (byte_done) begin
          bit_cnt_reg <= '0;
          shift_reg   <= '0;
          pix_cnt_reg <= tile_end ? '0 : pix_cnt_reg + 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          shift_reg   <= byte_word;
          pix_cnt_reg <= pix_cnt_reg + 1'b1;
        end
      end

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (drop) overflow_reg <= 1'b1;

      tile_done_reg <= pop && mem_last[rd_idx];
      if (pop && mem_last[rd_idx]) tile_count_reg <= tile_count_reg + 8'd1;
    end
  end

  // The storage has no reset. Stale entries are never visible, because the
  // read side is gated by out_valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_data[wr_idx] <= byte_word;
      mem_last[wr_idx] <= tile_end;
    end
  end

  assign out_valid  = !fifo_empty;
  assign out_data   = out_valid ? mem_data[rd_idx] : 8'h00;
  assign out_last   = out_valid && mem_last[rd_idx];
  assign tile_done  = tile_done_reg;
  assign overflow   = overflow_reg;
  assign tile_count = tile_count_reg;

endmodule

// File: tb/tb_edge_packer.sv
// tb_edge_packer
//   Directed bench for edge_packer with the default parameters.
//   A cycle table covers reset, bit packing across gaps in edge_valid,
//   holding the head byte, reset priority, and a write-while-empty. After
//   the table, hand-written sequences cover whole tiles, overflow, a
//   simultaneous pop and write while full, and reset in the middle of a
//   tile.
module tb_edge_packer;

  logic       clk = 1'b0;
  logic       reset;
  logic       edge_in;
  logic       edge_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       tile_done;
  logic       overflow;
  logic [7:0] tile_count;

  int n_checks = 0;
  int n_fail   = 0;

  edge_packer #(.TILE_BITS(324), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .edge_in    (edge_in),
    .edge_valid (edge_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .tile_done  (tile_done),
    .overflow   (overflow),
    .tile_count (tile_count)
  );

  always #5 clk = ~clk;

  // Pop monitor. Inputs change only just after a rising edge, so the values
  // seen at the falling edge decide what pops at the next rising edge.
  logic [8:0] cap_q [$];
  int         pulses = 0;
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) cap_q.push_back({out_last, out_data});
    if (tile_done) pulses++;
  end

  typedef struct packed {
    logic       rst;
    logic       ev;
    logic       ei;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_last;
    logic       exp_ovf;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic step(input logic r, input logic v, input logic b, input logic rdy);
    reset      = r;
    edge_valid = v;
    edge_in    = b;
    out_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ones(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy);
  endtask

  // Compare one captured tile: 40 full bytes followed by one last-tagged byte.
  task automatic check_tile(input string tag, input int base, input logic [7:0] full_b,
                            input logic [7:0] last_b);
    logic [8:0] exp;
    for (int k = 0; k < 41; k++) begin
      exp = (k == 40) ? {1'b1, last_b} : {1'b0, full_b};
      if (base + k < cap_q.size())
        check($sformatf("%s byte%0d", tag, k), cap_q[base + k], exp);
    end
  endtask

  initial begin
    int base;
    int pbase;

    reset = 1'b1; edge_valid = 1'b0; edge_in = 1'b0; out_ready = 1'b0;

    // Fields: rst ev ei rdy | valid data last ovf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    // Bits 1,1,0,0,1,0,1,1 with gaps; edge_in toggles while invalid
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hCB, 1'b0, 1'b0};
    // Head held while out_ready=0
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hCB, 1'b0, 1'b0};
    // Reset wins over a simultaneous bit and pop
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    // Eight ones with out_ready=1: pop cannot happen while empty
    for (int i = 15; i < 22; i++)
      vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].ev, vecs[i].ei, vecs[i].rdy);
      check($sformatf("vec%0d valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d data", i),  out_data,  vecs[i].exp_data);
      check($sformatf("vec%0d last", i),  out_last,  vecs[i].exp_last);
      check($sformatf("vec%0d ovf", i),   overflow,  vecs[i].exp_ovf);
      $display("vec%0d rst=%0b ev=%0b ei=%0b rdy=%0b -> valid=%0b data=%02h last=%0b ovf=%0b",
               i, vecs[i].rst, vecs[i].ev, vecs[i].ei, vecs[i].rdy,
               out_valid, out_data, out_last, overflow);
    end
    check("reset tile_count", tile_count, 0);
    check("reset tile_done", tile_done, 0);

    // Alternating tile 1,0,1,0,...
    step(1'b1, 1'b0, 1'b0, 1'b0);
    base = cap_q.size(); pbase = pulses;
    for (int i = 0; i < 324; i++) step(1'b0, 1'b1, (i % 2 == 0), 1'b1);
    idle(6, 1'b1);
    check("alt byte count", cap_q.size() - base, 41);
    check_tile("alt", base, 8'hAA, 8'hA0);
    check("alt tile_done pulses", pulses - pbase, 1);
    check("alt tile_count", tile_count, 1);
    check("alt overflow", overflow, 0);
    $display("alt tile: %0d bytes, tile_count=%0d", cap_q.size() - base, tile_count);

    // Two back-to-back all-ones tiles
    step(1'b1, 1'b0, 1'b0, 1'b0);
    base = cap_q.size(); pbase = pulses;
    send_ones(648, 1'b1);
    idle(6, 1'b1);
    check("ones byte count", cap_q.size() - base, 82);
    check_tile("ones t1", base, 8'hFF, 8'hF0);
    check_tile("ones t2", base + 41, 8'hFF, 8'hF0);
    check("ones tile_done pulses", pulses - pbase, 2);
    check("ones tile_count", tile_count, 2);
    $display("ones tiles: %0d bytes, tile_count=%0d", cap_q.size() - base, tile_count);

    // Overflow: FIFO fills with 4 bytes, the 5th byte is dropped
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_ones(32, 1'b0);
    check("ovf full valid", out_valid, 1);
    check("ovf full data", out_data, 8'hFF);
    send_ones(7, 1'b0);
    check("ovf before 5th", overflow, 0);
    send_ones(1, 1'b0);
    check("ovf after 5th", overflow, 1);
    base = cap_q.size();
    idle(10, 1'b1);
    check("ovf drained pops", cap_q.size() - base, 4);
    check("ovf drained valid", out_valid, 0);
    check("ovf sticky", overflow, 1);
    $display("overflow: %0d pops after drain, overflow=%0b", cap_q.size() - base, overflow);

    // Full FIFO, completing bit coincides with a pop
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_ones(39, 1'b0);
    base = cap_q.size();
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("simul ovf", overflow, 0);
    check("simul valid", out_valid, 1);
    idle(10, 1'b1);
    check("simul total pops", cap_q.size() - base, 5);
    check("simul ovf after", overflow, 0);
    $display("full write+pop: %0d pops, overflow=%0b", cap_q.size() - base, overflow);

    // Reset in the middle of a tile
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_ones(13, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("midreset valid", out_valid, 0);
    check("midreset data", out_data, 0);
    base = cap_q.size(); pbase = pulses;
    send_ones(8, 1'b1);
    idle(4, 1'b1);
    check("midreset pops", cap_q.size() - base, 1);
    if (cap_q.size() > base) check("midreset byte", cap_q[base], {1'b0, 8'hFF});
    check("midreset tile_count", tile_count, 0);
    check("midreset pulses", pulses - pbase, 0);
    $display("mid-tile reset: %0d pops, tile_count=%0d", cap_q.size() - base, tile_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_packer.md
EDGE_PACKER -- requirements
Module: edge_packer

Interface
REQ-001 Parameter TILE_BITS, 324, edge bits per tile (18x18 CANNY output); SHALL be >=1.
REQ-002 Parameter FIFO_DEPTH, 4, output byte FIFO entries; SHALL be a power of two >=2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high; SHALL take effect only at a rising edge of clk.
REQ-005 edge_in  input  1  edge bit from CANNY edge_out.
REQ-006 edge_valid  input  1  qualifier, driven by CANNY readable; edge_in SHALL be sampled only when edge_valid=1.
REQ-007 out_data  output  8  packed byte at FIFO head.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts; a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-010 out_last  output  1  head byte is final byte of a tile; valid only while out_valid=1.
REQ-011 tile_done  output  1  one-cycle pulse on pop of a byte with out_last=1.
REQ-012 overflow  output  1  sticky; a completed byte was dropped.
REQ-013 tile_count  output  8  count of tiles fully popped; wraps 255->0.

Function
REQ-014 Packing SHALL be MSB-first: first accepted bit of a byte lands in bit 7.
REQ-015 Internal counters: bit_cnt 0..7 (bits in current byte), pix_cnt 0..TILE_BITS-1 (bits in current tile).
REQ-016 On each accepted bit, pix_cnt and bit_cnt SHALL increment, except on byte completion as below.
REQ-017 A byte SHALL complete when bit_cnt=7 or pix_cnt=TILE_BITS-1 at the accepting edge.
REQ-018 A byte completed by pix_cnt=TILE_BITS-1 with fewer than 8 bits SHALL be zero-padded in the unused LSBs and tagged last; default TILE_BITS gives 40 full bytes + 1 byte holding 4 bits.
REQ-019 A byte completed by bit_cnt=7 that is also the tile's final bit SHALL be tagged last.
REQ-020 On completion, bit_cnt SHALL clear; pix_cnt SHALL clear if last, else increment.
REQ-021 The completed byte SHALL be written to the FIFO at the same edge that accepts the completing bit; out_valid SHALL be 1 in the following cycle (1-cycle latency when FIFO empty).
REQ-022 edge_valid=0: no counter, shift, or FIFO-write change; edge_in ignored.
REQ-023 FIFO SHALL be first-in-first-out; out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Write when FIFO full with no pop in the same cycle: byte SHALL be dropped, FIFO unchanged, overflow set to 1 from the next cycle until reset; counters SHALL still advance.
REQ-025 Write and pop in the same cycle while full SHALL both succeed; no overflow.
REQ-026 Write and pop in the same cycle while empty: pop does not occur (out_valid=0); write succeeds.
REQ-027 tile_done SHALL assert in the cycle after the popping edge of a last-tagged byte, for exactly one cycle; tile_count SHALL increment at that same edge.
REQ-028 No backpressure toward CANNY: bit acceptance SHALL never depend on FIFO state.

Reset
REQ-029 reset=1 SHALL clear bit_cnt, pix_cnt, shift register, FIFO pointers, overflow, tile_count, tile_done; out_valid=0, out_last=0, out_data=0 in the following cycle.
REQ-030 Reset mid-tile SHALL discard the partial byte and all FIFO contents; the next accepted bit SHALL start a new tile at bit 7.
REQ-031 reset SHALL have priority over simultaneous edge_valid and pop in the same cycle.

Verification
REQ-032 324 bits alternating 1,0 (start 1), edge_valid=1 continuous, out_ready=1 -> 40x 0xAA then 0xA0 with out_last=1; one tile_done pulse; tile_count=1; overflow=0.
REQ-033 All-ones tile, out_ready=1 -> 40x 0xFF, final 0xF0 with out_last=1; back-to-back second tile -> tile_count=2, second tile's first byte 0xFF.
REQ-034 out_ready=0, 40 ones -> first 4 bytes 0xFF retained, overflow=1 one cycle after 5th byte completes; then out_ready=1 -> exactly 4 pops, out_valid drops.
REQ-035 FIFO full, 8th bit of a new byte accepted in same cycle as pop -> byte stored, overflow stays 0, occupancy unchanged.
REQ-036 13 bits accepted then reset pulse -> out_valid=0 next cycle; 8 ones after reset -> single 0xFF, out_last=0, tile_count=0.
REQ-037 Bits 1,1,0,0,1,0,1,1 with random edge_valid gaps (edge_in toggling while invalid) -> single byte 0xCB.
